// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl
// Ramps the PWM duty value toward a commanded target, one step every
// 'hold' PWM periods. The duty value changes only on the edge where the
// PWM counter wraps, so the PWM stage never sees a torn period.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no ramp active, ready for a command, duty held
//   RAMP  | stepping duty toward target on period boundaries
module pwm_fade_ctrl #(
    parameter int CTRLEN = 8,
    parameter int HOLDW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CTRLEN-1:0] counter,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CTRLEN-1:0] cmd_target,
    input  logic [CTRLEN-1:0] cmd_step,
    input  logic [HOLDW-1:0]  cmd_hold,
    input  logic              abort,
    output logic [CTRLEN-1:0] duty_cycle,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

    state_t            state;
    state_t            state_nx;
    logic [CTRLEN-1:0] target_q;
    logic [CTRLEN-1:0] step_q;
    logic [HOLDW-1:0]  hold_q;
    logic [HOLDW-1:0]  hold_cnt;

    logic              pend;
    logic              accept;
    logic              step_at;
    logic [CTRLEN-1:0] step_eff;
    logic [HOLDW-1:0]  hold_eff;
    logic [CTRLEN:0]   sum;
    logic [CTRLEN:0]   diff;
    logic [CTRLEN-1:0] duty_nx;
    logic              lands;

    assign pend     = enable && (counter == {CTRLEN{1'b1}});
    assign accept   = cmd_valid && (state == IDLE);
    // hold_cnt is always >= 1 in RAMP; <= 1 also guards a stray zero
    assign step_at  = pend && (hold_cnt <= HOLDW'(1));
    assign step_eff = (cmd_step == '0) ? CTRLEN'(1) : cmd_step;
    assign hold_eff = (cmd_hold == '0) ? HOLDW'(1) : cmd_hold;

    // One extra bit so the sum cannot wrap and the difference reveals underflow
    assign sum  = {1'b0, duty_cycle} + {1'b0, step_q};
    assign diff = {1'b0, duty_cycle} - {1'b0, step_q};

    // Saturating step toward target: clamp so it never overshoots
    always_comb begin
        duty_nx = duty_cycle;
        if (target_q > duty_cycle) begin
            if (sum > {1'b0, target_q})
                duty_nx = target_q;
            else
                duty_nx = sum[CTRLEN-1:0];
        end else begin
            if ((duty_cycle < step_q) || (diff[CTRLEN-1:0] < target_q))
                duty_nx = target_q;
            else
                duty_nx = diff[CTRLEN-1:0];
        end
    end

    assign lands = (duty_nx == target_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; abort wins over a step landing on the same edge
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && (cmd_target != duty_cycle))
                    state_nx = RAMP;
            end
            RAMP: begin
                if (abort)
                    state_nx = IDLE;
                else if (step_at && lands)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE:    cmd_ready = 1'b1;
            RAMP:    busy      = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    // Command latch, hold counter, duty register and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q   <= '0;
            step_q     <= '0;
            hold_q     <= '0;
            hold_cnt   <= '0;
            duty_cycle <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // a pend in this cycle is deliberately not counted
                target_q <= cmd_target;
                step_q   <= step_eff;
                hold_q   <= hold_eff;
                hold_cnt <= hold_eff;
                if (cmd_target == duty_cycle)
                    done <= 1'b1;
            end else if ((state == RAMP) && !abort && pend) begin
                if (step_at) begin
                    duty_cycle <= duty_nx;
                    hold_cnt   <= hold_q;
                    if (lands)
                        done <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt - HOLDW'(1);
                end
            end
        end
    end

endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Duty-cycle sequencer that drives the `duty_cycle` input of the team's free-running PWM counter stage. It accepts fade commands (target duty, step size, periods per step) over a valid/ready handshake. It ramps its `duty_cycle` output toward the target, updating only at PWM period boundaries so that no period ever sees a torn duty value. It consumes the PWM stage's `counter` output to detect those boundaries.

## Interface
- `CTRLEN`, default 8: width of PWM counter and duty value; must match the PWM stage.
- `HOLDW`, default 8: width of the periods-per-step field.
- `clk`, input, 1: clock, shared with the PWM stage.
- `rst`, input, 1: reset, asynchronous, active-high.
- `enable`, input, 1: the same enable that drives the PWM stage's counter.
- `counter`, input, CTRLEN: PWM stage counter output.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: block can accept a command.
- `cmd_target`, input, CTRLEN: final duty value.
- `cmd_step`, input, CTRLEN: duty increment per step. 0 is treated as 1.
- `cmd_hold`, input, HOLDW: PWM periods per step. 0 is treated as 1.
- `abort`, input, 1: synchronous ramp cancel.
- `duty_cycle`, output, CTRLEN: registered duty value fed to the PWM stage.
- `busy`, output, 1: ramp in progress.
- `done`, output, 1: one-cycle pulse when a command completes.

## Operation
- Reset values: `duty_cycle`=0, `busy`=0, `done`=0, `cmd_ready`=1, state IDLE, hold counter 0.
- Period end: `pend = enable && counter == all-ones`. This marks the edge on which the PWM counter wraps to 0.
- States are IDLE and RAMP.
  - `cmd_ready` = (state==IDLE). `busy` = (state==RAMP).
- IDLE, when `cmd_valid && cmd_ready`:
  - Latch target, step (0→1) and hold (0→1). Load the hold counter with the latched hold value.
  - If target == `duty_cycle`: stay in IDLE and pulse `done` next cycle.
  - Otherwise: go to RAMP.
- RAMP:
  - On each `pend`, decrement the hold counter.
  - When the counter is 1 at a `pend`, apply a step on that edge and reload the counter with hold.
- Step arithmetic uses CTRLEN+1 bits, with no wrap and no overshoot:
  - Upward: `duty_cycle` = min(duty+step, target).
  - Downward: `duty_cycle` = max(duty−step, target). The subtraction must not underflow below 0.
- When a step lands on target: go to IDLE on that same edge, with `done`=1 for exactly the next cycle.
- `abort` in RAMP: go to IDLE next edge, `duty_cycle` holds its current value, no `done`. `abort` in IDLE has no effect.
- `abort` has priority over a step on the same edge. The step is discarded.
- `enable` low: `pend` never fires. The ramp pauses and the hold counter and duty are frozen. The ramp resumes when `enable` returns.
- `cmd_valid` while busy is ignored (not ready). The command must be held by the sender until it is accepted.
- `rst` asserted mid-ramp: all outputs take reset values immediately. The latched command is discarded.

## Timing
- Handshake: a command transfers on the edge where `cmd_valid && cmd_ready`. Fields need only be stable in that cycle.
- A `pend` in the acceptance cycle is not counted. Counting starts with the first `pend` after the acceptance edge.
- Duty updates occur only on a `pend` edge. The new value is therefore visible from `counter`=0 of the next PWM period.
- Step latency: the first step lands on the hold-th `pend` after acceptance.
  - Example, hold=1, CTRLEN=8, enable=1: first step ≤256 cycles after acceptance.
- `done` is high for one cycle, in the cycle after the final step edge. `cmd_ready` is high in that same cycle, so back-to-back commands are accepted with no gap.
- Zero-distance command: `done` is high the cycle after acceptance. `busy` never asserts.

## Test plan
- Reset mid-ramp:
  - Stimulus: ramp 0→200, step 10. Assert rst after 3 steps.
  - Response: `duty_cycle`=0, `busy`=0, `cmd_ready`=1 immediately. No `done`.
- Up ramp:
  - Stimulus: enable=1, command target=48, step=16, hold=1.
  - Response: `duty_cycle` is 16, 32, 48 on three successive `pend` edges. `done` pulses once after 48. `busy` is low afterwards.
- Saturating down ramp:
  - Stimulus: from 48, target=5, step=20, hold=2.
  - Response: `duty_cycle` is 28 after 2 periods, 8 after 4, 5 after 6. The value never goes below 5 and never wraps.
- Hold and enable pause:
  - Stimulus: hold=3, step=1. Drop enable for 1000 cycles mid-count.
  - Response: no duty change while enable is low. The step lands after a total of 3 counted `pend`s.
- Abort and back-to-back commands:
  - Stimulus: abort at `duty_cycle`=32 during a ramp to 128. Then issue target=32.
  - Response: the ramp stops at 32 with no `done`. The next command yields `done` one cycle after acceptance, with `busy` never high.
  - Stimulus: issue a second command in the `done` cycle.
  - Response: it is accepted in that cycle.
- Edge encodings:
  - Stimulus: step=0, hold=0, target=3 from 0.
  - Response: behaves as step 1, hold 1. `duty_cycle` is 1, 2, 3 on consecutive `pend`s.
  - Stimulus: target=255, step=255 from 250.
  - Response: `duty_cycle`=255 with no overflow.
